scr1_tb_axi_initiator: RTL and testbench

//  Testbench AXI4 initiator: converts a simple single-request memory interface (req/ack, resp pulse)

---
 rtl/scr1_tb_axi_pkg.sv | 48 ++++
 rtl/scr1_tb_axi_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_scr1_tb_axi_initiator.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tb_axi_pkg.sv
// Shared types and helpers for the testbench AXI4 initiator.
//  - axi_init_state_e : initiator FSM states
//  - AXI response / burst encodings
//  - lane_mask()  : byte-lane mask of an aligned access inside one data beat (max 8 lanes)
//  - size_legal() : access size fits the bus and the address is size-aligned
package scr1_tb_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR_DATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_ERR
  } axi_init_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // addr_lo: low address bits; max_size: log2(bytes per beat), at most 3.
  // Only meaningful for accesses that already passed size_legal().
  function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                           input logic [2:0] size,
                                           input logic [2:0] max_size);
    logic [7:0] base;
    logic [2:0] off;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    // byte offset of the access within the beat
    off = addr_lo & 3'((4'd1 << max_size) - 4'd1);
    return base << off;
  endfunction

  function automatic logic size_legal(input logic [2:0] addr_lo,
                                      input logic [2:0] size,
                                      input logic [2:0] max_size);
    // size is checked first; the alignment mask is only valid for size <= 3
    if (size > max_size) return 1'b0;
    return (addr_lo & 3'((4'd1 << size) - 4'd1)) == 3'd0;
  endfunction

endpackage

// File: rtl/scr1_tb_axi_initiator.sv
// Testbench AXI4 initiator: turns a single-request memory interface into
// single-beat AXI4 read/write transactions, one outstanding at a time.
// Ports:
//  clk, rst_n (async, active-low)
//  req/req_ack/req_we/req_addr/req_size/req_wdata/req_be : request side
//  resp_valid/resp_rdata/resp_err                        : completion side
//  aw*/w*/b*/ar*/r*                                      : AXI4 initiator port
// Each completed AXI transaction bumps a rolling ID; B/R responses are checked
// against it (plus response code and RLAST) and mismatches raise resp_err.
module scr1_tb_axi_initiator
  import scr1_tb_axi_pkg::*;
#(
  parameter int W_ID   = 4,
  parameter int W_ADR  = 32,
  parameter int W_DATA = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  output logic                req_ack,
  input  logic                req_we,
  input  logic [W_ADR-1:0]    req_addr,
  input  logic [2:0]          req_size,
  input  logic [W_DATA-1:0]   req_wdata,
  input  logic [W_DATA/8-1:0] req_be,
  output logic                resp_valid,
  output logic [W_DATA-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [W_ID-1:0]     awid,
  output logic [W_ADR-1:0]    awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic                wlast,
  output logic [W_DATA-1:0]   wdata,
  output logic [W_DATA/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [W_ID-1:0]     bid,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [W_ID-1:0]     arid,
  output logic [W_ADR-1:0]    araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [W_ID-1:0]     rid,
  input  logic [W_DATA-1:0]   rdata,
  input  logic                rlast,
  input  logic [1:0]          rresp
);

  localparam int         NB       = W_DATA / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(NB));

  axi_init_state_e state_q, state_d;

  logic [W_ADR-1:0]  addr_q;
  logic [2:0]        size_q;
  logic [W_DATA-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [W_ID-1:0]   id_q, id_d;

  logic              awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
  logic              resp_valid_d, resp_err_d;
  logic [W_DATA-1:0] rdata_d;
  logic              latch;
  logic              req_legal;
  logic [7:0]        lane_full;

  assign req_legal = size_legal(req_addr[2:0], req_size, MAX_SIZE);
  assign lane_full = lane_mask(req_addr[2:0], req_size, MAX_SIZE);
  assign req_ack   = (state_q == ST_IDLE);

  // Payload is held in registers, so it stays stable while a valid is high.
  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign awlen   = 8'd0;
  assign awburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;

  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid;
    wvalid_d     = wvalid;
    arvalid_d    = arvalid;
    bready_d     = bready;
    rready_d     = rready;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = resp_rdata;
    id_d         = id_q;
    latch        = 1'b0;
    case (state_q)
      ST_IDLE: if (req) begin
        latch = 1'b1;
        if (!req_legal) begin
          state_d = ST_ERR;
        end else if (req_we) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WADDR_DATA;
        end else begin
          arvalid_d = 1'b1;
          state_d   = ST_RADDR;
        end
      end
      ST_WADDR_DATA: begin
        // AW and W complete independently, in either order
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: if (bvalid) begin
        bready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = (bresp != AXI_RESP_OKAY) || (bid != id_q);
        id_d         = id_q + W_ID'(1);
        state_d      = ST_IDLE;
      end
      ST_RADDR: if (arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = ST_RDATA;
      end
      ST_RDATA: if (rvalid) begin
        rready_d     = 1'b0;
        rdata_d      = rdata;
        resp_valid_d = 1'b1;
        resp_err_d   = (rresp != AXI_RESP_OKAY) || (rid != id_q) || !rlast;
        id_d         = id_q + W_ID'(1);
        state_d      = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      arvalid    <= 1'b0;
      bready     <= 1'b0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      awvalid    <= awvalid_d;
      wvalid     <= wvalid_d;
      arvalid    <= arvalid_d;
      bready     <= bready_d;
      rready     <= rready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= rdata_d;
      id_q       <= id_d;
      if (latch) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        wstrb_q <= req_be & lane_full[NB-1:0];
      end
    end
  end

endmodule

// File: tb/tb_scr1_tb_axi_initiator.sv
// Directed bench for scr1_tb_axi_initiator: the bench plays the AXI slave by
// hand, cycle by cycle, and checks each output against hand-computed values.
module tb_scr1_tb_axi_initiator;

  logic        clk, rst_n;
  logic        req, req_ack, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_be;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic [1:0]  rresp;

  int n_cmp = 0;
  int n_mis = 0;

  scr1_tb_axi_initiator #(.W_ID(4), .W_ADR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_ack(req_ack), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awsize(awsize), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rlast(rlast), .rresp(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Write with slave ready on AW/W and a B response one cycle after the handshake.
  task automatic wr_txn(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                        input logic [3:0] be, input logic [3:0] exp_strb, input logic [3:0] exp_id,
                        input logic [3:0] bid_v, input logic [1:0] bresp_v, input logic exp_err);
    awready = 1'b1; wready = 1'b1;
    req = 1'b1; req_we = 1'b1; req_addr = addr; req_size = size; req_wdata = data; req_be = be;
    chk("wr_ack_c0", req_ack, 1);
    tick(); req = 1'b0;
    chk("wr_awvalid_c1", awvalid, 1);
    chk("wr_wvalid_c1", wvalid, 1);
    chk("wr_awaddr", awaddr, addr);
    chk("wr_awsize", awsize, size);
    chk("wr_awlen", awlen, 0);
    chk("wr_awburst", awburst, 1);
    chk("wr_wlast", wlast, 1);
    chk("wr_wdata", wdata, data);
    chk("wr_wstrb", wstrb, exp_strb);
    chk("wr_awid", awid, exp_id);
    tick();
    chk("wr_awvalid_c2", awvalid, 0);
    chk("wr_bready_c2", bready, 1);
    bvalid = 1'b1; bid = bid_v; bresp = bresp_v;
    tick(); bvalid = 1'b0;
    chk("wr_resp_valid_c3", resp_valid, 1);
    chk("wr_resp_err", resp_err, exp_err);
    chk("wr_ack_c3", req_ack, 1);
    chk("wr_bready_c3", bready, 0);
  endtask

  // Read with arready held low for 'delay' cycles, then R one cycle after AR handshake.
  task automatic rd_txn(input logic [31:0] addr, input logic [2:0] size, input int delay,
                        input logic [3:0] exp_id, input logic [31:0] rdata_v, input logic [3:0] rid_v,
                        input logic rlast_v, input logic [1:0] rresp_v, input logic exp_err);
    arready = 1'b0;
    req = 1'b1; req_we = 1'b0; req_addr = addr; req_size = size; req_be = 4'h0;
    tick(); req = 1'b0;
    chk("rd_arid", arid, exp_id);
    chk("rd_arsize", arsize, size);
    chk("rd_arlen", arlen, 0);
    for (int i = 0; i <= delay; i++) begin
      arready = (i == delay);
      chk("rd_arvalid_held", arvalid, 1);
      chk("rd_araddr_held", araddr, addr);
      tick();
    end
    arready = 1'b0;
    chk("rd_arvalid_drop", arvalid, 0);
    chk("rd_rready", rready, 1);
    rvalid = 1'b1; rdata = rdata_v; rid = rid_v; rlast = rlast_v; rresp = rresp_v;
    tick(); rvalid = 1'b0;
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_resp_rdata", resp_rdata, rdata_v);
    chk("rd_resp_err", resp_err, exp_err);
    chk("rd_rready_drop", rready, 0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; req_be = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rresp = '0;
    #12;
    chk("rst_req_ack", req_ack, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_awid", awid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst_n = 1'b1;
    tick();

    // 1: word write, id 0
    wr_txn(32'h100, 3'd2, 32'hDEADBEEF, 4'hF, 4'hF, 4'd0, 4'd0, 2'b00, 1'b0);
    tick();
    chk("t1_resp_pulse_end", resp_valid, 0);

    // 2: sub-word lane masks, ids 1 and 2 (back-to-back with no idle cycle)
    wr_txn(32'h103, 3'd0, 32'hAA000000, 4'hF, 4'h8, 4'd1, 4'd1, 2'b00, 1'b0);
    wr_txn(32'h102, 3'd1, 32'hBBBB0000, 4'hF, 4'hC, 4'd2, 4'd2, 2'b00, 1'b0);

    // 3: read with 5 cycles of back-pressure on AR, id 3
    rd_txn(32'h200, 3'd2, 5, 4'd3, 32'h12345678, 4'd3, 1'b1, 2'b00, 1'b0);

    // 4: W accepted at c1, AW accepted at c4, id 4
    awready = 1'b0; wready = 1'b1;
    req = 1'b1; req_we = 1'b1; req_addr = 32'h300; req_size = 3'd2; req_wdata = 32'h0; req_be = 4'hF;
    tick(); req = 1'b0;                            // c1
    chk("t4_wvalid_c1", wvalid, 1);
    chk("t4_awvalid_c1", awvalid, 1);
    tick(); wready = 1'b0;                         // c2
    chk("t4_wvalid_c2", wvalid, 0);
    chk("t4_awvalid_c2", awvalid, 1);
    chk("t4_bready_c2", bready, 0);
    tick();                                        // c3
    chk("t4_awvalid_c3", awvalid, 1);
    tick(); awready = 1'b1;                        // c4
    chk("t4_awvalid_c4", awvalid, 1);
    tick(); awready = 1'b0;                        // c5
    chk("t4_awvalid_c5", awvalid, 0);
    chk("t4_bready_c5", bready, 1);
    bvalid = 1'b1; bid = 4'd4; bresp = 2'b00;
    tick();                                        // c6: bvalid left high as a stray
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_resp_err", resp_err, 0);
    chk("t4_bready_idle", bready, 0);
    chk("t4_rdata_held", resp_rdata, 32'h12345678);
    tick(); bvalid = 1'b0;                         // c7
    chk("t4_single_b", resp_valid, 0);

    // 5: error cases
    wr_txn(32'h400, 3'd2, 32'h1, 4'hF, 4'hF, 4'd5, 4'd5, 2'b10, 1'b1);          // SLVERR, id 5
    rd_txn(32'h404, 3'd2, 0, 4'd6, 32'hCAFEF00D, 4'd7, 1'b1, 2'b00, 1'b1);     // rid mismatch
    rd_txn(32'h408, 3'd2, 0, 4'd7, 32'h0BADC0DE, 4'd7, 1'b0, 2'b00, 1'b1);     // rlast 0
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    req = 1'b1; req_we = 1'b1; req_addr = 32'h101; req_size = 3'd1; req_be = 4'hF;
    tick(); req = 1'b0;
    chk("t5_mis_awvalid", awvalid, 0);
    chk("t5_mis_wvalid", wvalid, 0);
    chk("t5_mis_ack_busy", req_ack, 0);
    chk("t5_mis_resp_early", resp_valid, 0);
    tick();
    chk("t5_mis_resp_valid", resp_valid, 1);
    chk("t5_mis_resp_err", resp_err, 1);
    chk("t5_mis_ack", req_ack, 1);
    req = 1'b1; req_we = 1'b0; req_addr = 32'h500; req_size = 3'd3;        // too wide for 32-bit bus
    tick(); req = 1'b0;
    chk("t5_big_arvalid", arvalid, 0);
    tick();
    chk("t5_big_resp_valid", resp_valid, 1);
    chk("t5_big_resp_err", resp_err, 1);
    tick();
    // errors do not consume an ID: next good read uses id 8
    rd_txn(32'h600, 3'd2, 0, 4'd8, 32'h55AA55AA, 4'd8, 1'b1, 2'b00, 1'b0);

    // 6: reset in the middle of a write
    awready = 1'b0; wready = 1'b0;
    req = 1'b1; req_we = 1'b1; req_addr = 32'h700; req_size = 3'd2; req_be = 4'hF;
    tick(); req = 1'b0;
    chk("t6_awvalid_pre", awvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_awvalid", awvalid, 0);
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_bready", bready, 0);
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_ack", req_ack, 1);
    #1 rst_n = 1'b1;
    tick();
    wr_txn(32'h104, 3'd2, 32'h13572468, 4'h3, 4'h3, 4'd0, 4'd0, 2'b00, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
